// File: rtl/cpc_fifo_pkg.sv
// Shared types and constants for the CPC host-side FIFO controller.
package cpc_fifo_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SI_PULSE,
    S_RD_HOLD,
    S_SOB_PULSE,
    S_RST,
    S_WAIT_END
  } state_e;

  typedef enum logic [2:0] {
    ACC_NONE,
    ACC_DW,
    ACC_DR,
    ACC_CW,
    ACC_SR
  } acc_e;

  localparam logic DATA_OFS = 1'b0;
  localparam logic STAT_OFS = 1'b1;

  localparam int ST_DOR = 0;
  localparam int ST_DIR = 1;
  localparam int ST_OVF = 2;
  localparam int ST_UNF = 3;

  localparam int CMD_RST = 0;
  localparam int CMD_CLR = 1;

  localparam int PW_W = 4;

  // A write strobe takes priority if a malformed cycle shows both strobes low.
  function automatic acc_e classify(input logic sel, input logic a0,
                                    input logic rd_b, input logic wr_b);
    if (!sel)
      return ACC_NONE;
    if (!wr_b)
      return (a0 == DATA_OFS) ? ACC_DW : ACC_CW;
    if (!rd_b)
      return (a0 == DATA_OFS) ? ACC_DR : ACC_SR;
    return ACC_NONE;
  endfunction

endpackage

// File: rtl/cpc_pulse_gen.sv
// Loadable down-counter; output is active while the count is non-zero.
module cpc_pulse_gen #(
  parameter int                CNT_W     = 4,
  parameter logic [CNT_W-1:0]  RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] width,
  output logic             active,
  output logic             last
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      cnt <= RESET_VAL;
    else if (load)
      cnt <= width;
    else if (cnt != '0)
      cnt <= cnt - 1'b1;
  end

  assign active = (cnt != '0);
  assign last   = (cnt == CNT_W'(1));

endmodule

// File: rtl/cpc_fifo_host_ctrl.sv
// Z80 I/O decode and 40105 FIFO sequencing for the CPC side of the CPC<->Pi link.
module cpc_fifo_host_ctrl
  import cpc_fifo_pkg::*;
#(
  parameter logic [15:0] BASE_ADDR  = 16'hFD80,
  parameter int unsigned SI_CYCLES  = 1,
  parameter int unsigned SOB_CYCLES = 1,
  parameter int unsigned RST_CYCLES = 4
) (
  input  logic        CLK,
  input  logic        RESET_B,
  input  logic [11:0] a_hi,
  input  logic        a1,
  input  logic        a0,
  input  logic        IOREQ_B,
  input  logic        RD_B,
  input  logic        WR_B,
  input  logic [7:0]  d_in,
  output logic [7:0]  d_out,
  output logic        d_oe,
  input  logic        fifo_host_dir,
  input  logic        fifo_host_dor,
  output logic        host_fifo_si,
  output logic        host_fifo_sob,
  output logic        host_fifo_oeb,
  output logic        host_fifo_reset
);

  localparam logic [PW_W-1:0] SI_W  = PW_W'(SI_CYCLES);
  localparam logic [PW_W-1:0] SOB_W = PW_W'(SOB_CYCLES);
  localparam logic [PW_W-1:0] RST_W = PW_W'(RST_CYCLES);

  state_e     state;
  acc_e       acc;
  logic       addr_hit;
  logic       hit;
  logic       ioreq_b_p1;
  logic       rd_b_p1;
  logic       wr_b_p1;
  logic       dir_p1;
  logic       dor_p1;
  logic       dor_at_start;
  logic       overflow;
  logic       underflow;
  logic       si_load, si_active, si_last;
  logic       sob_load, sob_active, sob_last;
  logic       rst_load, rst_active, rst_last;
  logic [5:0] unused_d_in;

  assign unused_d_in = d_in[7:2];

  // Stage p0: combinational decode, fast enough for the Z80 read data setup.
  assign addr_hit = (a_hi == BASE_ADDR[15:4]) && !a1;
  assign hit      = addr_hit && !IOREQ_B;

  assign host_fifo_oeb = !(hit && (a0 == DATA_OFS) && !RD_B && (state != S_RST));
  assign d_oe          = hit && (a0 == STAT_OFS) && !RD_B;

  always_comb begin
    d_out         = '0;
    d_out[ST_DOR] = fifo_host_dor;
    d_out[ST_DIR] = fifo_host_dir;
    d_out[ST_OVF] = overflow;
    d_out[ST_UNF] = underflow;
  end

  // Stage p1: bus strobes and FIFO handshakes sampled once on CLK.
  always_ff @(posedge CLK or negedge RESET_B) begin
    if (!RESET_B) begin
      ioreq_b_p1 <= 1'b1;
      rd_b_p1    <= 1'b1;
      wr_b_p1    <= 1'b1;
    end else begin
      ioreq_b_p1 <= IOREQ_B;
      rd_b_p1    <= RD_B;
      wr_b_p1    <= WR_B;
    end
  end

  always_ff @(posedge CLK) begin
    dir_p1 <= fifo_host_dir;
    dor_p1 <= fifo_host_dor;
  end

  // Address lines are stable for the whole I/O cycle, so they qualify the registered strobes directly.
  assign acc = classify(addr_hit && !ioreq_b_p1, a0, rd_b_p1, wr_b_p1);

  assign si_load  = (state == S_IDLE) && (acc == ACC_DW) && dir_p1;
  assign sob_load = (state == S_RD_HOLD) && rd_b_p1 && dor_at_start;
  assign rst_load = (state == S_IDLE) && (acc == ACC_CW) && d_in[CMD_RST];

  cpc_pulse_gen #(.CNT_W(PW_W), .RESET_VAL('0)) u_si_pulse (
    .clk    (CLK),
    .rst_n  (RESET_B),
    .load   (si_load),
    .width  (SI_W),
    .active (si_active),
    .last   (si_last)
  );

  cpc_pulse_gen #(.CNT_W(PW_W), .RESET_VAL('0)) u_sob_pulse (
    .clk    (CLK),
    .rst_n  (RESET_B),
    .load   (sob_load),
    .width  (SOB_W),
    .active (sob_active),
    .last   (sob_last)
  );

  // Reset value keeps the FIFO master reset asserted for RST_CYCLES after RESET_B releases.
  cpc_pulse_gen #(.CNT_W(PW_W), .RESET_VAL(RST_W)) u_rst_pulse (
    .clk    (CLK),
    .rst_n  (RESET_B),
    .load   (rst_load),
    .width  (RST_W),
    .active (rst_active),
    .last   (rst_last)
  );

  assign host_fifo_si    = si_active;
  assign host_fifo_sob   = !sob_active;
  assign host_fifo_reset = rst_active;

  // Stage p2: sequencer; WAIT_END enforces one action per I/O cycle.
  always_ff @(posedge CLK or negedge RESET_B) begin
    if (!RESET_B) begin
      state        <= S_IDLE;
      overflow     <= 1'b0;
      underflow    <= 1'b0;
      dor_at_start <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          unique case (acc)
            ACC_DW: begin
              if (dir_p1) begin
                state <= S_SI_PULSE;
              end else begin
                overflow <= 1'b1;
                state    <= S_WAIT_END;
              end
            end
            ACC_DR: begin
              dor_at_start <= dor_p1;
              state        <= S_RD_HOLD;
            end
            ACC_CW: begin
              if (d_in[CMD_CLR]) begin
                overflow  <= 1'b0;
                underflow <= 1'b0;
              end
              state <= d_in[CMD_RST] ? S_RST : S_WAIT_END;
            end
            ACC_SR:   state <= S_WAIT_END;
            default:  state <= S_IDLE;
          endcase
        end
        S_SI_PULSE: begin
          if (si_last)
            state <= S_WAIT_END;
        end
        S_RD_HOLD: begin
          if (rd_b_p1) begin
            if (dor_at_start) begin
              state <= S_SOB_PULSE;
            end else begin
              underflow <= 1'b1;
              state     <= S_WAIT_END;
            end
          end
        end
        S_SOB_PULSE: begin
          if (sob_last)
            state <= S_WAIT_END;
        end
        S_RST: begin
          if (rst_last)
            state <= S_WAIT_END;
        end
        S_WAIT_END: begin
          if (ioreq_b_p1)
            state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cpc_fifo_host_ctrl.sv
// Scoreboard bench: stimulus queues expected pulse/status events, a negedge monitor matches them.
module tb_cpc_fifo_host_ctrl;

  logic        CLK = 1'b0;
  logic        RESET_B = 1'b0;
  logic [11:0] a_hi = 12'hFD8;
  logic        a1 = 1'b0;
  logic        a0 = 1'b0;
  logic        IOREQ_B = 1'b1;
  logic        RD_B = 1'b1;
  logic        WR_B = 1'b1;
  logic [7:0]  d_in = 8'h00;
  logic [7:0]  d_out;
  logic        d_oe;
  logic        fifo_host_dir = 1'b0;
  logic        fifo_host_dor = 1'b0;
  logic        host_fifo_si;
  logic        host_fifo_sob;
  logic        host_fifo_oeb;
  logic        host_fifo_reset;

  cpc_fifo_host_ctrl dut (
    .CLK             (CLK),
    .RESET_B         (RESET_B),
    .a_hi            (a_hi),
    .a1              (a1),
    .a0              (a0),
    .IOREQ_B         (IOREQ_B),
    .RD_B            (RD_B),
    .WR_B            (WR_B),
    .d_in            (d_in),
    .d_out           (d_out),
    .d_oe            (d_oe),
    .fifo_host_dir   (fifo_host_dir),
    .fifo_host_dor   (fifo_host_dor),
    .host_fifo_si    (host_fifo_si),
    .host_fifo_sob   (host_fifo_sob),
    .host_fifo_oeb   (host_fifo_oeb),
    .host_fifo_reset (host_fifo_reset)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    string name;
    int    val;
  } obs_t;

  obs_t exp_q[$];
  int   n_total = 0;
  int   n_pass  = 0;

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic push(input string name, input int val);
    obs_t e;
    e.name = name;
    e.val  = val;
    exp_q.push_back(e);
  endtask

  task automatic emit(input string name, input int val);
    obs_t e;
    n_total++;
    if (exp_q.size() == 0) begin
      $display("FAIL unexpected_%s: got 0x%0h, expected no event", name, val);
    end else begin
      e = exp_q.pop_front();
      if (e.name == name && e.val == val) n_pass++;
      else $display("FAIL %s: got %s=0x%0h, expected %s=0x%0h", e.name, name, val, e.name, e.val);
    end
  endtask

  // Posedge bookkeeping: cycle of first WR_B-low sample and first RD_B-high sample.
  int   cyc = 0;
  int   wr_fall = 0;
  int   rd_rise = 0;
  logic wr_prev = 1'b1;
  logic rd_prev = 1'b1;

  always @(posedge CLK) begin
    cyc <= cyc + 1;
    if (!WR_B && wr_prev) wr_fall <= cyc + 1;
    if (RD_B && !rd_prev) rd_rise <= cyc + 1;
    wr_prev <= WR_B;
    rd_prev <= RD_B;
  end

  // Monitor: events are reported as latency*16 + width (pulses) or sampled values.
  int   si_start = 0, si_w = 0, sob_start = 0, sob_w = 0;
  int   oeb_w = 0, rst_w = 0, st_val = 0;
  logic si_p = 1'b0, sob_p = 1'b1, oeb_p = 1'b1, doe_p = 1'b0, rst_p = 1'b0;

  always @(negedge CLK) begin
    if (host_fifo_si) begin
      if (!si_p) si_start <= cyc;
      si_w <= si_w + 1;
    end else if (si_p) begin
      emit("si", (si_start - wr_fall) * 16 + si_w);
      si_w <= 0;
    end
    if (!host_fifo_sob) begin
      if (sob_p) sob_start <= cyc;
      sob_w <= sob_w + 1;
    end else if (!sob_p) begin
      emit("sob", (sob_start - rd_rise) * 16 + sob_w);
      sob_w <= 0;
    end
    if (!host_fifo_oeb) begin
      oeb_w <= oeb_w + 1;
    end else if (!oeb_p) begin
      emit("oeb", oeb_w);
      oeb_w <= 0;
    end
    if (d_oe) begin
      st_val <= int'(d_out);
    end else if (doe_p) begin
      emit("status", st_val);
    end
    if (host_fifo_reset) begin
      if (RESET_B) rst_w <= rst_w + 1;
    end else if (rst_p) begin
      emit("fifo_reset", rst_w);
      rst_w <= 0;
    end
    si_p  <= host_fifo_si;
    sob_p <= host_fifo_sob;
    oeb_p <= host_fifo_oeb;
    doe_p <= d_oe;
    rst_p <= host_fifo_reset;
  end

  task automatic set_addr(input logic [15:0] addr);
    a_hi = addr[15:4];
    a1   = addr[1];
    a0   = addr[0];
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge CLK);
    #2;
  endtask

  task automatic io_write(input logic [15:0] addr, input logic [7:0] data, input int n);
    @(posedge CLK);
    #2;
    set_addr(addr);
    d_in    = data;
    IOREQ_B = 1'b0;
    WR_B    = 1'b0;
    repeat (n) @(posedge CLK);
    #2;
    IOREQ_B = 1'b1;
    WR_B    = 1'b1;
  endtask

  task automatic io_read(input logic [15:0] addr, input int n);
    @(posedge CLK);
    #2;
    set_addr(addr);
    IOREQ_B = 1'b0;
    RD_B    = 1'b0;
    repeat (n) @(posedge CLK);
    #2;
    IOREQ_B = 1'b1;
    RD_B    = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: got no completion, expected end of stimulus");
    $fatal(1, "bench timeout");
  end

  initial begin
    // Reset state
    repeat (3) @(posedge CLK);
    #1;
    check("rst_si", int'(host_fifo_si), 0);
    check("rst_sob", int'(host_fifo_sob), 1);
    check("rst_fifo_reset", int'(host_fifo_reset), 1);
    check("rst_d_oe", int'(d_oe), 0);
    check("rst_oeb", int'(host_fifo_oeb), 1);
    check("rst_d_out", int'(d_out), 0);
    push("fifo_reset", 4);
    @(posedge CLK);
    #2;
    RESET_B = 1'b1;
    idle(8);

    // Data write with space: one-cycle SI one cycle after WR_B sampled low
    fifo_host_dir = 1'b1;
    idle(2);
    push("si", 8'h11);
    io_write(16'hFD80, 8'h5A, 3);
    idle(3);

    // Data write with no space: overflow, no SI
    fifo_host_dir = 1'b0;
    idle(2);
    io_write(16'hFD80, 8'h33, 3);
    idle(3);
    push("status", 8'h04);
    io_read(16'hFD81, 3);
    idle(3);

    // Data read with data available: OEB for the whole read, SOB after RD_B rises
    fifo_host_dir = 1'b1;
    fifo_host_dor = 1'b1;
    idle(2);
    push("oeb", 3);
    push("sob", 8'h11);
    io_read(16'hFD80, 3);
    idle(4);
    push("status", 8'h07);
    io_read(16'hFD81, 3);
    idle(3);

    // Data read with FIFO empty: underflow, no SOB
    fifo_host_dor = 1'b0;
    idle(2);
    push("oeb", 3);
    io_read(16'hFD80, 3);
    idle(3);
    push("status", 8'h0E);
    io_read(16'hFD81, 3);
    idle(3);

    // FIFO reset command; a data write inside the window is dropped without a flag
    fifo_host_dir = 1'b0;
    idle(2);
    push("fifo_reset", 4);
    io_write(16'hFD81, 8'h01, 3);
    io_write(16'hFD80, 8'hA5, 3);
    idle(6);
    push("status", 8'h0C);
    io_read(16'hFD81, 3);
    idle(3);
    io_write(16'hFD81, 8'h02, 3);
    idle(3);
    push("status", 8'h00);
    io_read(16'hFD81, 3);
    idle(3);

    // Non-decoded addresses produce no activity
    fifo_host_dir = 1'b1;
    fifo_host_dor = 1'b1;
    idle(2);
    io_write(16'hFD82, 8'h11, 3);
    io_read(16'hFD82, 3);
    io_write(16'hFE80, 8'h22, 3);
    io_read(16'hFE80, 3);
    io_read(16'hFD83, 3);
    idle(3);

    // Long I/O cycle still yields exactly one SI
    push("si", 8'h11);
    io_write(16'hFD80, 8'h44, 6);
    idle(3);

    // Set overflow, then abort an SI pulse with RESET_B
    fifo_host_dir = 1'b0;
    fifo_host_dor = 1'b0;
    idle(2);
    io_write(16'hFD80, 8'h55, 3);
    idle(3);
    fifo_host_dir = 1'b1;
    idle(2);
    @(posedge CLK);
    #2;
    set_addr(16'hFD80);
    d_in    = 8'h66;
    IOREQ_B = 1'b0;
    WR_B    = 1'b0;
    @(posedge CLK);
    @(posedge CLK);
    #2;
    check("abort_si_started", int'(host_fifo_si), 1);
    push("fifo_reset", 4);
    RESET_B = 1'b0;
    #1;
    check("abort_si", int'(host_fifo_si), 0);
    check("abort_sob", int'(host_fifo_sob), 1);
    check("abort_fifo_reset", int'(host_fifo_reset), 1);
    @(posedge CLK);
    #2;
    IOREQ_B = 1'b1;
    WR_B    = 1'b1;
    @(posedge CLK);
    #2;
    RESET_B = 1'b1;
    idle(8);
    push("si", 8'h11);
    io_write(16'hFD80, 8'h77, 3);
    idle(3);
    push("status", 8'h02);
    io_read(16'hFD81, 3);
    idle(10);

    check("queue_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
